mdu_issue_ctrl: RTL and testbench

//  Initiator side of the multiply/divide unit interface. Sits in the E stage between
//  the pipeline and the MDU. Gates the E-stage MDU opcode into a one-cycle issue and

---
 rtl/mdu_issue_ctrl.sv | 80 ++++++++
 tb/tb_mdu_issue_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: one-cycle issue gating, a mirror
// of the MDU latency countdown for D-stage stalls, and a sticky protocol checker.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       e_valid_i,
    input  logic [3:0] e_mdu_op_i,
    input  logic       e_flush_i,
    input  logic       d_uses_mdu_i,
    input  logic       mdu_busy_i,
    output logic [3:0] mdu_op_o,
    output logic       stall_d_o,
    output logic [3:0] cnt_out_o,
    output logic       proto_err_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       first_run_q;
    logic       proto_err_q;

    logic op_mul, op_div, op_busy, op_mdu, op_unknown;
    logic live, cnt_nz, issue, issue_busy, viol;

    always_comb begin
        op_mul     = (e_mdu_op_i == 4'd1) || (e_mdu_op_i == 4'd2);
        op_div     = (e_mdu_op_i == 4'd3) || (e_mdu_op_i == 4'd4);
        op_busy    = op_mul || op_div;
        op_mdu     = op_busy || (e_mdu_op_i == 4'd7) || (e_mdu_op_i == 4'd8);
        op_unknown = !op_mdu && (e_mdu_op_i != 4'd0);
        live       = e_valid_i && !e_flush_i;
        cnt_nz     = (cnt_q != 4'd0);
        issue      = live && op_mdu && !cnt_nz && !mdu_busy_i;
        issue_busy = issue && op_busy;
        // The MDU's Busy lags the issue edge, so skip the agreement check in the first RUN cycle.
        viol       = (live && op_mdu && (cnt_nz || mdu_busy_i))
                  || (!first_run_q && (mdu_busy_i != cnt_nz))
                  || (live && op_unknown);
    end

    assign mdu_op_o    = issue ? e_mdu_op_i : 4'd0;
    assign stall_d_o   = d_uses_mdu_i && (issue_busy || cnt_nz || mdu_busy_i);
    assign cnt_out_o   = cnt_q;
    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            first_run_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            first_run_q <= issue_busy;
            proto_err_q <= proto_err_q || viol;
            case (state_q)
                IDLE: begin
                    if (issue_busy) begin
                        cnt_q   <= op_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // A flush never aborts a running operation; the count always runs out.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU driving Busy.
module tb_mdu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset_i, e_valid_i, e_flush_i, d_uses_mdu_i, mdu_busy_i;
    logic [3:0] e_mdu_op_i, mdu_op_o, cnt_out_o;
    logic       stall_d_o, proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] op;
        logic       stall;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk_i(clk), .reset_i(reset_i), .e_valid_i(e_valid_i), .e_mdu_op_i(e_mdu_op_i),
        .e_flush_i(e_flush_i), .d_uses_mdu_i(d_uses_mdu_i), .mdu_busy_i(mdu_busy_i),
        .mdu_op_o(mdu_op_o), .stall_d_o(stall_d_o), .cnt_out_o(cnt_out_o),
        .proto_err_o(proto_err_o)
    );

    // Behavioural MDU: Busy goes high the cycle after an accepted mult/div op.
    int mdu_cnt = 0;
    always @(posedge clk) begin
        if (reset_i) mdu_cnt <= 0;
        else if (mdu_op_o == 4'd1 || mdu_op_o == 4'd2) mdu_cnt <= 5;
        else if (mdu_op_o == 4'd3 || mdu_op_o == 4'd4) mdu_cnt <= 10;
        else if (mdu_cnt > 0) mdu_cnt <= mdu_cnt - 1;
    end
    assign mdu_busy_i = (mdu_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("mdu_op",    32'(mdu_op_o),    32'(e.op));
            chk("stall_d",   32'(stall_d_o),   32'(e.stall));
            chk("cnt_out",   32'(cnt_out_o),   32'(e.cnt));
            chk("proto_err", 32'(proto_err_o), 32'(e.err));
        end
    end

    task automatic step(input logic rst, input logic v, input logic [3:0] op, input logic fl,
                        input logic du, input logic [3:0] eop, input logic est,
                        input logic [3:0] ecnt, input logic eerr);
        exp_t e;
        reset_i = rst; e_valid_i = v; e_mdu_op_i = op; e_flush_i = fl; d_uses_mdu_i = du;
        e.op = eop; e.stall = est; e.cnt = ecnt; e.err = eerr;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_i = 1'b1; e_valid_i = 1'b0; e_mdu_op_i = 4'd0; e_flush_i = 1'b0; d_uses_mdu_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 1: mult issue, six stall cycles
        step(0, 1, 1, 0, 1, 1, 1, 0, 0);
        for (int i = 5; i >= 1; i--) step(0, 0, 0, 0, 1, 0, 1, 4'(i), 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 2: divu with mflo waiting in D
        step(0, 1, 4, 0, 1, 4, 1, 0, 0);
        for (int i = 10; i >= 1; i--) step(0, 0, 0, 0, 1, 0, 1, 4'(i), 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 3: flush at issue
        step(0, 1, 3, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 4: mthi / mtlo back to back
        step(0, 1, 7, 0, 1, 7, 0, 0, 0);
        step(0, 1, 8, 0, 1, 8, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 5: op while counting -> sticky error
        step(0, 1, 1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 4, 0);
        step(0, 1, 2, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: reset mid-div, then immediate mult
        step(0, 1, 3, 0, 1, 3, 1, 0, 0);
        for (int i = 10; i >= 5; i--) step(0, 0, 0, 0, 1, 0, 1, 4'(i), 0);
        step(1, 0, 0, 0, 1, 0, 1, 4, 0);
        step(0, 1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 5; i >= 1; i--) step(0, 0, 0, 0, 1, 0, 1, 4'(i), 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Unknown opcode: no issue, no stall, error next cycle
        step(0, 1, 5, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        if (sbq.size() != 0) chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
